// File: rtl/rf_dump_pkg.sv
// ----------------------------------------------------------------------------
// rf_dump_pkg: shared widths and FSM state encoding for the register dump reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rf_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int SETTLE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_dump_reader.sv
// ----------------------------------------------------------------------------
// rf_dump_reader: stalls the CPU and streams registers FIRST_REG..LAST_REG out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int FIRST_REG     = 1,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  cpu_hold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A     = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A      = REG_ADDR_W'(LAST_REG);
  localparam logic [SETTLE_W-1:0]   SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      rd_addr    <= FIRST_A;
      out_data   <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      // Abort outranks everything, including a handshake on this same edge.
      state     <= ST_IDLE;
      rd_addr   <= FIRST_A;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state    <= ST_DRAIN;
            rd_addr  <= FIRST_A;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state      <= ST_SETTLE;
          settle_cnt <= SETTLE_INIT;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            out_data  <= rd_data;
            out_index <= rd_addr;
            out_valid <= 1'b1;
            out_last  <= (rd_addr == LAST_A);
            state     <= ST_SEND;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_index == LAST_A) begin
              state    <= ST_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              rd_addr    <= rd_addr + 1'b1;
              settle_cnt <= SETTLE_INIT;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
// ----------------------------------------------------------------------------
// tb_rf_dump_reader: scoreboard bench for the default and a narrow dump config
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  logic clk, reset;
  logic start0, abort0, ready0, start1, abort1, ready1;
  logic [4:0]  rd_addr0, rd_addr1, out_index0, out_index1;
  logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
  logic cpu_hold0, out_valid0, out_last0, busy0, done0;
  logic cpu_hold1, out_valid1, out_last1, busy1, done1;

  logic [31:0] regs0 [32];
  logic [31:0] regs1 [32];
  assign rd_data0 = regs0[rd_addr0];
  assign rd_data1 = regs1[rd_addr1];

  word_t q0[$];
  word_t q1[$];
  int n_cmp = 0;
  int n_err = 0;

  rf_dump_reader dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .cpu_hold(cpu_hold0),
    .out_valid(out_valid0), .out_ready(ready0), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0), .busy(busy0), .done(done0)
  );

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(3), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .cpu_hold(cpu_hold1),
    .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_all0();
    word_t w;
    q0 = {};
    for (int r = 1; r <= 31; r++) begin
      w.idx = 5'(r); w.data = 32'h1000_0000 + 32'(r);
      q0.push_back(w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid0, out_last0, cpu_hold0, busy0, done0, out_data0, out_index0, rd_addr0} !== {5'b0, 32'h0, 5'd0, 5'd1}) begin
      n_err++; $display("FAIL reset_dut0: got v%b l%b h%b b%b d%b data %h idx %0d addr %0d", out_valid0, out_last0, cpu_hold0, busy0, done0, out_data0, out_index0, rd_addr0);
    end
    n_cmp++;
    if ({out_valid1, out_last1, cpu_hold1, busy1, done1, out_data1, out_index1, rd_addr1} !== {5'b0, 32'h0, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL reset_dut1: got v%b h%b b%b d%b data %h idx %0d addr %0d, want all 0", out_valid1, cpu_hold1, busy1, done1, out_data1, out_index1, rd_addr1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_dump();
    int n; word_t e;
    push_all0();
    ready0 = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; n = 0;
    for (int t = 0; t < 70; t++) begin
      n_cmp++;
      if (cpu_hold0 !== (t <= 62)) begin n_err++; $display("FAIL full_hold t=%0d: got %b want %b", t, cpu_hold0, (t <= 62)); end
      n_cmp++;
      if (done0 !== (t == 63)) begin n_err++; $display("FAIL full_done t=%0d: got %b want %b", t, done0, (t == 63)); end
      n_cmp++;
      if (out_last0 !== (out_valid0 && out_index0 == 5'd31)) begin n_err++; $display("FAIL full_last t=%0d: got %b idx %0d", t, out_last0, out_index0); end
      if (out_valid0 && ready0) begin
        n_cmp++;
        if (q0.size() == 0) begin n_err++; $display("FAIL full_extra: got idx %0d want none", out_index0); end
        else begin
          e = q0.pop_front();
          if (out_index0 !== e.idx || out_data0 !== e.data) begin n_err++; $display("FAIL full_word: got %0d/%h want %0d/%h", out_index0, out_data0, e.idx, e.data); end
        end
        n_cmp++;
        if (t != 2 + 2 * n) begin n_err++; $display("FAIL full_hs_time: got t=%0d want %0d", t, 2 + 2 * n); end
        n++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n != 31 || q0.size() != 0 || busy0 !== 1'b0) begin n_err++; $display("FAIL full_end: got words %0d left %0d busy %b want 31/0/0", n, q0.size(), busy0); end
  endtask

  task automatic test_back_pressure();
    int n; bit seen, pv, pr; logic [31:0] pd; logic [4:0] pi; word_t e;
    push_all0();
    ready0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; n = 0; seen = 0; pv = 0; pr = 0; pd = '0; pi = '0;
    for (int t = 0; t < 400 && !seen; t++) begin
      ready0 = ((t % 3) == 2);
      if (pv && !pr) begin
        n_cmp++;
        if (out_valid0 !== 1'b1 || out_data0 !== pd || out_index0 !== pi) begin n_err++; $display("FAIL bp_stable: got v%b %0d/%h want 1 %0d/%h", out_valid0, out_index0, out_data0, pi, pd); end
      end
      if (out_valid0) begin
        n_cmp++;
        if (cpu_hold0 !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b want 1", cpu_hold0); end
      end
      if (out_valid0 && ready0) begin
        n_cmp++;
        if (q0.size() == 0) begin n_err++; $display("FAIL bp_extra: got idx %0d want none", out_index0); end
        else begin
          e = q0.pop_front();
          if (out_index0 !== e.idx || out_data0 !== e.data) begin n_err++; $display("FAIL bp_word: got %0d/%h want %0d/%h", out_index0, out_data0, e.idx, e.data); end
        end
        n++;
      end
      pv = out_valid0; pr = ready0; pd = out_data0; pi = out_index0;
      @(posedge clk); #1;
      if (done0) seen = 1;
    end
    n_cmp++;
    if (!seen || n != 31 || q0.size() != 0) begin n_err++; $display("FAIL bp_end: got done %0d words %0d left %0d want 1/31/0", seen, n, q0.size()); end
    ready0 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit aborted; word_t e;
    push_all0();
    ready0 = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; aborted = 0;
    for (int t = 0; t < 100 && !aborted; t++) begin
      if (out_valid0 && out_index0 == 5'd5) begin
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0; aborted = 1;
      end else begin
        if (out_valid0 && ready0 && q0.size() != 0) begin
          e = q0.pop_front();
          n_cmp++;
          if (out_index0 !== e.idx || out_data0 !== e.data) begin n_err++; $display("FAIL abort_word: got %0d/%h want %0d/%h", out_index0, out_data0, e.idx, e.data); end
        end
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (!aborted || out_valid0 !== 1'b0 || busy0 !== 1'b0 || cpu_hold0 !== 1'b0 || done0 !== 1'b0) begin
      n_err++; $display("FAIL abort_state: got seen %0d v%b b%b h%b d%b want 1 0 0 0 0", aborted, out_valid0, busy0, cpu_hold0, done0);
    end
    n_cmp++;
    if (q0.size() != 27) begin n_err++; $display("FAIL abort_count: got left %0d want 27", q0.size()); end
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL abort_after: got d%b b%b want 0 0", done0, busy0); end
    end
    q0 = {};
  endtask

  task automatic test_param_variant();
    int n, th; bit seen, pv; word_t w, e;
    q1 = {};
    for (int r = 0; r <= 3; r++) begin
      w.idx = 5'(r); w.data = regs1[r];
      q1.push_back(w);
    end
    ready1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; n = 0; th = 0; seen = 0; pv = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      if (out_valid1 && !pv) begin
        n_cmp++;
        if (n == 0 && t != 4) begin n_err++; $display("FAIL var_first: got t=%0d want 4", t); end
        else if (n > 0 && (t - th - 1) != 3) begin n_err++; $display("FAIL var_gap: got %0d want 3", t - th - 1); end
      end
      if (out_valid1 && ready1) begin
        n_cmp++;
        if (q1.size() == 0) begin n_err++; $display("FAIL var_extra: got idx %0d want none", out_index1); end
        else begin
          e = q1.pop_front();
          if (out_index1 !== e.idx || out_data1 !== e.data || out_last1 !== (e.idx == 5'd3)) begin
            n_err++; $display("FAIL var_word: got %0d/%h last %b want %0d/%h", out_index1, out_data1, out_last1, e.idx, e.data);
          end
        end
        th = t; n++;
      end
      pv = out_valid1;
      @(posedge clk); #1;
      if (done1) seen = 1;
    end
    n_cmp++;
    if (!seen || n != 4 || q1.size() != 0) begin n_err++; $display("FAIL var_end: got done %0d words %0d left %0d want 1/4/0", seen, n, q1.size()); end
  endtask

  task automatic test_start_edges();
    int n, nd;
    push_all0();
    ready0 = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; n = 0; nd = 0;
    for (int t = 0; t < 80; t++) begin
      start0 = (t == 5);
      if (out_valid0 && ready0) begin void'(q0.pop_front()); n++; end
      @(posedge clk); #1;
      if (done0) nd++;
    end
    start0 = 1'b0;
    n_cmp++;
    if (n != 31 || nd != 1 || busy0 !== 1'b0) begin n_err++; $display("FAIL busy_start: got words %0d dones %0d busy %b want 31/1/0", n, nd, busy0); end
    start0 = 1'b1; abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; abort0 = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b0 || cpu_hold0 !== 1'b0) begin n_err++; $display("FAIL start_abort: got b%b h%b want 0 0", busy0, cpu_hold0); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy0 !== 1'b0) begin n_err++; $display("FAIL start_abort_late: got b%b want 0", busy0); end
  endtask

  task automatic test_reset_mid_dump();
    ready0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    n_cmp++;
    if (busy0 !== 1'b1 || out_valid0 !== 1'b1) begin n_err++; $display("FAIL pre_reset: got b%b v%b want 1 1", busy0, out_valid0); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid0, out_last0, cpu_hold0, busy0, done0, out_data0, out_index0, rd_addr0} !== {5'b0, 32'h0, 5'd0, 5'd1}) begin
      n_err++; $display("FAIL reset_mid: got v%b h%b b%b d%b data %h idx %0d addr %0d", out_valid0, cpu_hold0, busy0, done0, out_data0, out_index0, rd_addr0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ready0 = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;
    for (int r = 0; r < 32; r++) begin
      regs0[r] = 32'h1000_0000 + 32'(r);
      regs1[r] = (r == 0) ? 32'h0 : 32'h2000_0000 + 32'(r * 3);
    end
    test_reset();
    test_full_dump();
    test_back_pressure();
    test_abort();
    test_param_variant();
    test_start_edges();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_dump_reader.md
# rf_dump_reader

Debug read-out engine for the single-cycle CPU's general-purpose register file. On a start request it freezes the core, walks registers FIRST_REG..LAST_REG through one register-file read port, and presents each value on a valid/ready word stream toward the debug/UART bridge. It is the reader counterpart to the register file's write port. The only write traffic it has to coordinate with is the CPU itself, which it stalls via `cpu_hold`.

## Interface
- `FIRST_REG`, default 1: first register number dumped; 0 ≤ FIRST_REG ≤ LAST_REG.
- `LAST_REG`, default 31: last register number dumped; ≤ 31.
- `SETTLE_CYCLES`, default 1: cycles between driving `rd_addr` and sampling `rd_data`; range 1..15.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin dump; sampled only in IDLE.
- `abort`  in  1  terminate dump immediately; highest priority.
- `rd_addr`  out  5  read-port register number to the register file.
- `rd_data`  in  32  combinational read data from the register file.
- `cpu_hold`  out  1  stalls PC update and RegWrite while high.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  sink accepts word.
- `out_data`  out  32  captured register value.
- `out_index`  out  5  register number of `out_data`.
- `out_last`  out  1  `out_valid` && `out_index` == LAST_REG.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- **States:** IDLE, DRAIN, SETTLE, SEND, DONE. All outputs are registered.
- **IDLE:** `start` && !`abort` at an edge → DRAIN. `rd_addr` is set to FIRST_REG and `cpu_hold` goes to 1.
- **DRAIN:** lasts one cycle and lets a CPU write already in flight retire. Then → SETTLE with the settle counter set to SETTLE_CYCLES-1.
- **SETTLE:** the counter decrements each cycle. At the edge where it reads 0, the block captures `rd_data` → `out_data`, captures `rd_addr` → `out_index`, sets `out_valid`=1, and → SEND.
- **SEND:** holds `out_data` and `out_index` stable while `out_valid` && !`out_ready`. On a handshake edge:
  - if `out_index` == LAST_REG: `out_valid`=0, → DONE.
  - otherwise: `rd_addr` += 1, `out_valid`=0, → SETTLE.
- **DONE:** lasts one cycle. `done`=1 and `cpu_hold`=0, then → IDLE.
- **`cpu_hold`** is 1 in DRAIN, SETTLE and SEND only.
- **Abort:** `abort` at any edge outside IDLE → IDLE. It clears `out_valid` and `cpu_hold`, produces no `done` pulse, and takes priority over a simultaneous handshake.
- **`start` while busy:** ignored.
- **`start` and `abort` together in IDLE:** the block stays IDLE.
- **Register 0:** if FIRST_REG=0, register 0 is dumped as read (0x00000000). It gets no special handling.
- **Address width:** `rd_addr` never increments past LAST_REG, so there is no wrap.

## Timing
- **Reset values:** state IDLE, `rd_addr`=FIRST_REG, `out_data`=0, `out_index`=0. `out_valid`, `out_last`, `cpu_hold`, `busy` and `done` are all 0.
- **Reset mid-dump:** same effect as abort, applied asynchronously.
- **Start latency:** `start` sampled at edge k → `cpu_hold`/`busy` high after k. With SETTLE_CYCLES=S, first `out_valid` is high after edge k+1+S.
- **Per-word gap:** after a handshake at edge h, the next `out_valid` is high after edge h+S. `out_valid` is low for exactly S cycles between words.
- **Full dump, `out_ready`=1, S=1, defaults:** handshakes at k+3+2n for n=0..30. The last handshake is at k+63. `done` is high in the cycle after k+63, and the block is IDLE with `cpu_hold`=0 after k+64.
- **Back-pressure:** `out_ready` low stretches SEND indefinitely. `cpu_hold` stays high throughout.

## Structure
- **Shared package `rf_dump_pkg`:** state enum, REG_ADDR_W=5, DATA_W=32, SETTLE_W=4.
- **Sub-modules:** none. The FSM, settle counter and output register are all contained in `rf_dump_reader`.

## Test plan
- **Defaults, S=1, `out_ready`=1:** preload register r = 0x1000_0000+r, pulse `start` → 31 words, index 1..31, data 0x1000_0001..0x1000_001F. `out_last` only on index 31. `done` pulse at k+64. `cpu_hold` high exactly k+1..k+63.
- **Back-pressure:** `out_ready` toggles 1-of-3 cycles → no word lost or duplicated. `out_data`/`out_index` stay stable while stalled.
- **Abort:** `abort` during SEND of index 5 with `out_ready`=1 → no handshake counted, IDLE next cycle, `done` stays 0, `cpu_hold` drops.
- **Parameter variant:** FIRST_REG=0, LAST_REG=3, S=3 → four words; index 0 data 0. Gap between words is 3 cycles.
- **Reset and start edge cases:**
  - reset asserted mid-dump → all outputs at reset values immediately.
  - `start` while busy → ignored.
  - `start` with `abort` in IDLE → stays IDLE.
